// File: rtl/lp_pkg.sv
// Shared types and constants for the LP problem feeder.
package lp_pkg;

  localparam int unsigned NUM_ENTRIES = 7;
  localparam int unsigned NUM_CONS    = 6;
  localparam int unsigned A_W         = 6;
  localparam int unsigned B_W         = 12;

  typedef logic signed [A_W-1:0] coef_t;
  typedef logic signed [B_W-1:0] rhs_t;

  localparam coef_t COEF_POS  = coef_t'(1);
  localparam coef_t COEF_NEG  = coef_t'(-1);
  localparam coef_t COEF_ZERO = coef_t'(0);

  localparam rhs_t RESULT_TIMEOUT = rhs_t'(-2048);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSend,
    StWait,
    StFin
  } state_e;

endpackage

// File: rtl/lp_entry_check.sv
// Combinational sanity check of the six constraint rows: each unit bound
// (+x, -x, +y, -y) appears exactly once and exactly two rows are general.
module lp_entry_check
  import lp_pkg::*;
(
  input  coef_t a1 [NUM_CONS],
  input  coef_t a2 [NUM_CONS],
  output logic  pass
);

  logic [2:0] cnt_px, cnt_nx, cnt_py, cnt_ny, cnt_other;

  always_comb begin
    cnt_px    = '0;
    cnt_nx    = '0;
    cnt_py    = '0;
    cnt_ny    = '0;
    cnt_other = '0;
    for (int i = 0; i < NUM_CONS; i++) begin
      if (a1[i] == COEF_POS && a2[i] == COEF_ZERO) begin
        cnt_px = cnt_px + 3'd1;
      end else if (a1[i] == COEF_NEG && a2[i] == COEF_ZERO) begin
        cnt_nx = cnt_nx + 3'd1;
      end else if (a1[i] == COEF_ZERO && a2[i] == COEF_POS) begin
        cnt_py = cnt_py + 3'd1;
      end else if (a1[i] == COEF_ZERO && a2[i] == COEF_NEG) begin
        cnt_ny = cnt_ny + 3'd1;
      end else begin
        cnt_other = cnt_other + 3'd1;
      end
    end
    pass = (cnt_px == 3'd1) && (cnt_nx == 3'd1) && (cnt_py == 3'd1) &&
           (cnt_ny == 3'd1) && (cnt_other == 3'd2);
  end

endmodule

// File: rtl/lp_feeder.sv
// Holds a small 2-variable LP problem, validates it, streams it to a solver
// and captures the solver's answer with a bounded wait.
module lp_feeder
  import lp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic signed [A_W-1:0] cfg_a1,
  input  logic signed [A_W-1:0] cfg_a2,
  input  logic signed [B_W-1:0] cfg_b,
  input  logic                  start,
  output logic                  busy,
  output logic                  lp_in_valid,
  output logic signed [A_W-1:0] lp_in_a1,
  output logic signed [A_W-1:0] lp_in_a2,
  output logic signed [B_W-1:0] lp_in_b,
  input  logic                  lp_out_valid,
  input  logic signed [B_W-1:0] lp_out_max_value,
  output logic                  done,
  output logic signed [B_W-1:0] result,
  output logic                  cfg_err,
  output logic                  timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  coef_t           a1_q [NUM_ENTRIES];
  coef_t           a2_q [NUM_ENTRIES];
  rhs_t            b_q  [NUM_ENTRIES];
  logic [2:0]      beat_q;
  logic [CntW-1:0] wait_cnt_q;
  rhs_t            result_q;
  logic            cfg_err_q, timeout_q;

  coef_t chk_a1 [NUM_CONS];
  coef_t chk_a2 [NUM_CONS];
  logic  check_pass;
  logic  last_beat, wait_expired;

  always_comb begin
    for (int i = 0; i < NUM_CONS; i++) begin
      chk_a1[i] = a1_q[i+1];
      chk_a2[i] = a2_q[i+1];
    end
  end

  lp_entry_check u_entry_check (
    .a1   (chk_a1),
    .a2   (chk_a2),
    .pass (check_pass)
  );

  assign last_beat    = (beat_q == 3'(NUM_ENTRIES - 1));
  assign wait_expired = (wait_cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StCheck;
      StCheck: state_d = check_pass ? StSend : StFin;
      StSend:  if (last_beat) state_d = StWait;
      // A response in the final counted cycle wins over the timeout.
      StWait:  if (lp_out_valid || wait_expired) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StFin);
    lp_in_valid = (state_q == StSend);
    lp_in_a1    = '0;
    lp_in_a2    = '0;
    lp_in_b     = '0;
    if (lp_in_valid) begin
      lp_in_a1 = a1_q[beat_q];
      lp_in_a2 = a2_q[beat_q];
      // Objective row carries no right-hand side.
      if (beat_q != 3'd0) lp_in_b = b_q[beat_q];
    end
  end

  assign result  = result_q;
  assign cfg_err = cfg_err_q;
  assign timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        a1_q[i] <= '0;
        a2_q[i] <= '0;
        b_q[i]  <= '0;
      end
      beat_q     <= '0;
      wait_cnt_q <= '0;
      result_q   <= '0;
      cfg_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && cfg_we) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (cfg_addr == 3'(i)) begin
            a1_q[i] <= cfg_a1;
            a2_q[i] <= cfg_a2;
            b_q[i]  <= cfg_b;
          end
        end
      end
      case (state_q)
        StCheck: begin
          cfg_err_q <= !check_pass;
          timeout_q <= 1'b0;
          beat_q    <= '0;
        end
        StSend: begin
          beat_q     <= beat_q + 3'd1;
          wait_cnt_q <= '0;
        end
        StWait: begin
          if (lp_out_valid) begin
            result_q <= lp_out_max_value;
          end else if (wait_expired) begin
            timeout_q <= 1'b1;
            result_q  <= RESULT_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lp_feeder.md
LP_FEEDER -- requirements
Module: lp_feeder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1048575: cycles allowed in WAIT for lp_out_valid before abort.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cfg_we  input  1  write strobe for one problem entry.
REQ-005 cfg_addr  input  3  entry index; 0 = objective (c1,c2), 1..6 = constraints; 7 ignored.
REQ-006 cfg_a1, cfg_a2  input  6 signed  entry coefficients.
REQ-007 cfg_b  input  12 signed  entry right-hand side; stored but never transmitted for entry 0.
REQ-008 start  input  1  single-cycle launch request.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 lp_in_valid, lp_in_a1 (6 signed), lp_in_a2 (6 signed), lp_in_b (12 signed)  output  solver input stream.
REQ-011 lp_out_valid  input  1; lp_out_max_value  input  12 signed  solver result.
REQ-012 done  output  1  one-cycle pulse at end of every launch.
REQ-013 result  output  12 signed  captured max value; held until next done.
REQ-014 cfg_err, timeout  output  1 each  status of the last launch; valid from done until the next start.

Function
REQ-015 States: IDLE, CHECK, SEND, WAIT, FIN; enum from lp_pkg.
REQ-016 IDLE: cfg_we writes entry cfg_addr; cfg_we with start in the same cycle commits the write first, so the launch uses the new value.
REQ-017 cfg_we outside IDLE is ignored; start outside IDLE is ignored.
REQ-018 IDLE + start -> CHECK; CHECK clears cfg_err and timeout.
REQ-019 CHECK lasts exactly 1 cycle; entries 1..6 must hold each of (1,0), (-1,0), (0,1), (0,-1) exactly once, plus exactly 2 other pairs.
REQ-020 Check fail -> cfg_err=1, go to FIN; nothing is transmitted.
REQ-021 Check pass -> SEND; lp_in_valid is high for exactly 7 consecutive cycles, carrying entries 0..6 in order.
REQ-022 lp_in_b = 0 in the entry-0 cycle; lp_in_* = 0 whenever lp_in_valid = 0.
REQ-023 Cycle after the last SEND beat -> WAIT; lp_in_valid is low; the wait counter starts at 0.
REQ-024 WAIT + lp_out_valid -> result <= lp_out_max_value, go to FIN.
REQ-025 WAIT with counter == TIMEOUT_CYCLES-1 and no lp_out_valid -> timeout=1, result <= -2048, go to FIN.
REQ-026 lp_out_valid coinciding with the timeout cycle counts as success.
REQ-027 lp_out_valid outside WAIT is ignored.
REQ-028 FIN lasts 1 cycle with done=1, then -> IDLE; a new start is accepted in the following IDLE cycle.
REQ-029 Stored entries persist across launches; relaunching without writes retransmits identical data.
REQ-030 Latency start -> first lp_in_valid: exactly 2 cycles; start -> done on the check-fail path: 2 cycles.

Reset
REQ-031 rst_n low forces, asynchronously: state IDLE; busy, lp_in_valid, lp_in_*, done, cfg_err, timeout = 0; result = 0; counters 0; entry registers 0.
REQ-032 Reset during SEND or WAIT aborts the launch; lp_in_valid is low from reset assertion; no done pulse is produced.

Structure
REQ-033 lp_pkg holds the state enum, NUM_ENTRIES=7, A_W=6, B_W=12, and RESULT_TIMEOUT = -2048.
REQ-034 A single sub-module, lp_entry_check (combinational; 6 entries in, pass out), implements REQ-019.

Verification
REQ-035 Load (3,2); (1,0,4); (-1,0,0); (0,1,5); (0,-1,0); (1,1,6); (1,-1,2); start; behavioural solver returns 16 -> 7 beats in order, done with result=16, cfg_err=0, timeout=0.
REQ-036 Same load with entry 4 rewritten to (1,0,4) -> cfg_err=1, done 2 cycles after start, no lp_in_valid.
REQ-037 TIMEOUT_CYCLES=100, solver silent -> done exactly 100 cycles after WAIT entry; timeout=1; result=-2048.
REQ-038 start plus cfg_we(addr 0, (5,-1)) in the same cycle -> first beat carries (5,-1,0); a second start during WAIT is ignored.
REQ-039 rst_n pulsed low at the 4th SEND beat -> lp_in_valid drops immediately, all outputs 0, and a fresh launch afterwards sends the all-zero entries, giving cfg_err=1.
